// File: rtl/c432_key_loader.sv
// c432_key_loader: serial key intake for the locked c432 core.
// Accepts a 46-bit LSB-first frame (41 XOR bits, 4 mux bits, even parity)
// over a valid/ready stream. The key is presented to the core only after
// the parity check passes. Failed loads are counted, and repeated failures
// lock the loader until reset.
module c432_key_loader #(
  parameter int unsigned KEY_X_W  = 41,
  parameter int unsigned KEY_P_W  = 4,
  parameter int unsigned TIMEOUT  = 64,
  parameter int unsigned MAX_FAIL = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_start,
  input  logic               sin_bit,
  input  logic               sin_valid,
  output logic               sin_ready,
  output logic [KEY_X_W-1:0] key_x,
  output logic [KEY_P_W-1:0] key_p,
  output logic               key_armed,
  output logic               key_error,
  output logic               key_lockout,
  output logic [1:0]         fail_cnt
);

  localparam int unsigned SH_W  = KEY_X_W + KEY_P_W;
  localparam int unsigned FRAME = SH_W + 1;
  localparam int unsigned BC_W  = $clog2(FRAME);
  localparam int unsigned IC_W  = $clog2(TIMEOUT + 1);

  localparam logic [BC_W-1:0] LAST_BIT   = BC_W'(FRAME - 1);
  localparam logic [IC_W-1:0] IDLE_LIMIT = IC_W'(TIMEOUT - 1);
  localparam logic [1:0]      FAIL_MAX   = 2'(MAX_FAIL);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_ARMED,
    S_ERROR,
    S_LOCKOUT
  } state_t;

  state_t            state, next_state;
  logic [SH_W-1:0]   shadow;
  logic [BC_W-1:0]   bit_cnt;
  logic [IC_W-1:0]   idle_cnt;
  logic              parity;
  logic              accept;
  logic              fail_event;
  logic              arm_event;
  logic              enter_load;
  logic [1:0]        fail_inc;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next-state logic plus the arm/fail events that drive the output registers
  always_comb begin
    accept     = sin_valid & sin_ready;
    fail_inc   = (fail_cnt == FAIL_MAX) ? fail_cnt : fail_cnt + 2'd1;
    next_state = state;
    fail_event = 1'b0;
    arm_event  = 1'b0;
    case (state)
      S_IDLE: begin
        if (load_start) next_state = S_LOAD;
      end
      S_LOAD: begin
        // An accepted bit takes precedence over timeout expiry on the same edge
        if (accept && bit_cnt == LAST_BIT) next_state = S_CHECK;
        else if (!accept && idle_cnt == IDLE_LIMIT) fail_event = 1'b1;
      end
      S_CHECK: begin
        if (!parity) begin
          next_state = S_ARMED;
          arm_event  = 1'b1;
        end else begin
          fail_event = 1'b1;
        end
      end
      S_ARMED, S_ERROR: begin
        if (load_start) next_state = S_LOAD;
      end
      S_LOCKOUT: next_state = S_LOCKOUT;
      default:   next_state = S_IDLE;
    endcase
    if (fail_event) next_state = (fail_inc == FAIL_MAX) ? S_LOCKOUT : S_ERROR;
    enter_load = (next_state == S_LOAD) && (state != S_LOAD);
  end

  // Frame capture, counters and registered key/status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sin_ready   <= 1'b0;
      shadow      <= '0;
      bit_cnt     <= '0;
      idle_cnt    <= '0;
      parity      <= 1'b0;
      key_x       <= '0;
      key_p       <= '0;
      key_armed   <= 1'b0;
      key_error   <= 1'b0;
      key_lockout <= 1'b0;
      fail_cnt    <= '0;
    end else begin
      sin_ready <= (next_state == S_LOAD);

      if (enter_load) begin
        bit_cnt   <= '0;
        idle_cnt  <= '0;
        parity    <= 1'b0;
        key_x     <= '0;
        key_p     <= '0;
        key_armed <= 1'b0;
        key_error <= 1'b0;
      end else if (state == S_LOAD) begin
        if (accept) begin
          parity   <= parity ^ sin_bit;
          idle_cnt <= '0;
          bit_cnt  <= bit_cnt + 1'b1;
          // Shift right so the first (LSB) bit ends up in shadow[0]; the
          // parity bit itself is not stored.
          if (bit_cnt != LAST_BIT) shadow <= {sin_bit, shadow[SH_W-1:1]};
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end

      if (arm_event) begin
        key_x     <= shadow[KEY_X_W-1:0];
        key_p     <= shadow[SH_W-1:KEY_X_W];
        key_armed <= 1'b1;
        key_error <= 1'b0;
        fail_cnt  <= '0;
      end

      if (fail_event) begin
        key_x     <= '0;
        key_p     <= '0;
        key_armed <= 1'b0;
        key_error <= 1'b1;
        fail_cnt  <= fail_inc;
        if (fail_inc == FAIL_MAX) key_lockout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_c432_key_loader.sv
// Testbench for c432_key_loader: a table of key frames is driven through
// the serial port, with expected key/status pushed to a scoreboard queue and
// popped when the result appears. Hand sequences cover timeout, lockout and
// asynchronous reset.
module tb_c432_key_loader;

  localparam int unsigned KX = 41;
  localparam int unsigned KP = 4;
  localparam int unsigned TO = 64;
  localparam int unsigned MF = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_start;
  logic          sin_bit;
  logic          sin_valid;
  logic          sin_ready;
  logic [KX-1:0] key_x;
  logic [KP-1:0] key_p;
  logic          key_armed;
  logic          key_error;
  logic          key_lockout;
  logic [1:0]    fail_cnt;

  c432_key_loader #(
    .KEY_X_W (KX),
    .KEY_P_W (KP),
    .TIMEOUT (TO),
    .MAX_FAIL(MF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .sin_bit    (sin_bit),
    .sin_valid  (sin_valid),
    .sin_ready  (sin_ready),
    .key_x      (key_x),
    .key_p      (key_p),
    .key_armed  (key_armed),
    .key_error  (key_error),
    .key_lockout(key_lockout),
    .fail_cnt   (fail_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [KX-1:0] x;
    logic [KP-1:0] p;
    bit            bad;
    int            gap;
  } vec_t;

  typedef struct {
    logic [KX-1:0] x;
    logic [KP-1:0] p;
    logic          armed;
    logic          error;
    logic [1:0]    fail;
  } exp_t;

  exp_t       sb[$];
  vec_t       vecs[6];
  int         n_vec  = 0;
  int         n_fail = 0;
  logic [1:0] exp_fail = 2'd0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_bit(input logic b);
    int   w;
    logic rdy;
    w = 0;
    sin_valid = 1'b1;
    sin_bit   = b;
    forever begin
      rdy = sin_ready;
      tick();
      if (rdy) break;
      w++;
      if (w > 200) begin
        n_vec++;
        n_fail++;
        $display("FAIL handshake_wait: sin_ready stayed 0 for %0d cycles, required 1", w);
        break;
      end
    end
    sin_valid = 1'b0;
    sin_bit   = 1'b0;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("load_sin_ready", sin_ready, 1);
    chk("load_armed_clr", key_armed, 0);
    chk("load_key_x_clr", key_x, 0);
    chk("load_key_p_clr", key_p, 0);
    chk("load_error_clr", key_error, 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_key_x"}, key_x, 0);
    chk({tag, "_key_p"}, key_p, 0);
    chk({tag, "_sin_ready"}, sin_ready, 0);
    chk({tag, "_armed"}, key_armed, 0);
    chk({tag, "_error"}, key_error, 0);
    chk({tag, "_lockout"}, key_lockout, 0);
    chk({tag, "_fail_cnt"}, fail_cnt, 0);
  endtask

  task automatic apply_reset();
    rst        = 1'b1;
    load_start = 1'b0;
    sin_valid  = 1'b0;
    sin_bit    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b0;
    exp_fail = 2'd0;
  endtask

  task automatic run_frame(input vec_t v);
    logic [KX+KP:0] f;
    exp_t           e;
    exp_t           got;
    f = {(^{v.p, v.x}) ^ v.bad, v.p, v.x};
    if (v.bad) begin
      exp_fail = (exp_fail == 2'(MF)) ? exp_fail : exp_fail + 2'd1;
      e.x = '0; e.p = '0; e.armed = 1'b0; e.error = 1'b1; e.fail = exp_fail;
    end else begin
      exp_fail = 2'd0;
      e.x = v.x; e.p = v.p; e.armed = 1'b1; e.error = 1'b0; e.fail = 2'd0;
    end
    sb.push_back(e);
    start_load();
    for (int i = 0; i <= KX + KP; i++) begin
      send_bit(f[i]);
      if (i < KX + KP) idle_cycles(v.gap);
    end
    // One edge after the parity-bit handshake: verdict not yet visible
    chk("check_cycle_armed", key_armed, 0);
    chk("check_cycle_key_x", key_x, 0);
    tick();
    got = sb.pop_front();
    chk("res_key_x", key_x, got.x);
    chk("res_key_p", key_p, got.p);
    chk("res_armed", key_armed, got.armed);
    chk("res_error", key_error, got.error);
    chk("res_fail_cnt", fail_cnt, got.fail);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    vec_t v;

    vecs[0].x = '1;                         vecs[0].p = 4'hA; vecs[0].bad = 0; vecs[0].gap = 2;
    vecs[1].x = '1;                         vecs[1].p = 4'hA; vecs[1].bad = 1; vecs[1].gap = 1;
    vecs[2].x = 41'h0AAAAAAAAAA;            vecs[2].p = 4'h5; vecs[2].bad = 0; vecs[2].gap = 0;
    vecs[3].x = KX'({$urandom, $urandom});  vecs[3].p = 4'h3; vecs[3].bad = 0; vecs[3].gap = 3;
    vecs[4].x = KX'({$urandom, $urandom});  vecs[4].p = 4'hC; vecs[4].bad = 1; vecs[4].gap = 0;
    vecs[5].x = KX'({$urandom, $urandom});  vecs[5].p = 4'h9; vecs[5].bad = 0; vecs[5].gap = 1;

    // Reset with no stimulus
    apply_reset();
    idle_cycles(10);
    check_all_zero("reset");

    // Table of good / bad-parity frames, reloading from ARMED and ERROR
    for (int i = 0; i < 6; i++) run_frame(vecs[i]);

    // Timeout: 20 bits then silence; expiry lands on the TIMEOUT-th idle edge
    start_load();
    for (int i = 0; i < 20; i++) send_bit(1'(i));
    idle_cycles(TO - 1);
    chk("to_before_ready", sin_ready, 1);
    chk("to_before_error", key_error, 0);
    idle_cycles(1);
    chk("to_error", key_error, 1);
    chk("to_ready", sin_ready, 0);
    chk("to_armed", key_armed, 0);
    chk("to_fail_cnt", fail_cnt, 1);

    // A bit accepted on the expiry edge keeps LOAD and restarts the idle count
    start_load();
    for (int i = 0; i < 20; i++) send_bit(1'(i));
    idle_cycles(TO - 1);
    send_bit(1'b1);
    chk("to_save_ready", sin_ready, 1);
    chk("to_save_error", key_error, 0);
    idle_cycles(TO - 1);
    chk("to_save2_ready", sin_ready, 1);
    idle_cycles(1);
    chk("to_save2_error", key_error, 1);
    chk("to_save2_fail_cnt", fail_cnt, 2);

    // Lockout after three consecutive bad loads
    apply_reset();
    v.x = '1; v.p = 4'hA; v.bad = 1; v.gap = 0;
    for (int i = 0; i < 3; i++) run_frame(v);
    chk("lock_lockout", key_lockout, 1);
    chk("lock_fail_cnt", fail_cnt, 3);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("lock_ignore_ready", sin_ready, 0);
    idle_cycles(3);
    chk("lock_hold_ready", sin_ready, 0);
    chk("lock_hold_lockout", key_lockout, 1);
    chk("lock_hold_key_x", key_x, 0);
    apply_reset();
    check_all_zero("lock_rst");

    // Asynchronous reset partway through a load, after one failed load
    v.x = 41'h12345678; v.p = 4'h1; v.bad = 1; v.gap = 0;
    run_frame(v);
    start_load();
    for (int i = 0; i < 30; i++) send_bit(1'(i % 3 == 0));
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    @(posedge clk);
    #1;
    rst      = 1'b0;
    exp_fail = 2'd0;

    // Clean reload after the aborted frame
    v.x = 41'h0AAAAAAAAAA; v.p = 4'h5; v.bad = 0; v.gap = 1;
    run_frame(v);

    // Reload from ARMED drops the key on the load edge
    start_load();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
